// File: rtl/crossover_gene_aligner_pkg.sv
// Shared definitions for the crossover gene aligner: state encoding,
// gene key field bounds and configuration word field offsets.
package crossover_gene_aligner_pkg;

  localparam int GENE_SZ = 64;
  localparam int ATTR_SZ = 8;
  localparam int CNT_W   = 16;

  // Gene key sits in attribute slots 5 and 6; its MSB is the gene type.
  localparam int KEY_HI = 7*ATTR_SZ - 1;
  localparam int KEY_LO = 5*ATTR_SZ;
  localparam int KEY_W  = KEY_HI - KEY_LO + 1;

  localparam int P1_FIT_HI   = 63;
  localparam int P1_FIT_LO   = 56;
  localparam int P2_FIT_HI   = 55;
  localparam int P2_FIT_LO   = 48;
  localparam int CHILD_ID_HI = 7;
  localparam int CHILD_ID_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/crossover_gene_aligner_gene_merge_decide.sv
// Combinational NEAT inheritance decision for the two parent stream heads:
// which heads to consume, whether a pair is emitted and how it is formed.
module gene_merge_decide
  import crossover_gene_aligner_pkg::*;
(
  input  logic             i_p1_valid,
  input  logic             i_p2_valid,
  input  logic             i_p1_ex,
  input  logic             i_p2_ex,
  input  logic [KEY_W-1:0] i_key1,
  input  logic [KEY_W-1:0] i_key2,
  input  logic             i_bias,
  output logic             o_consume1,
  output logic             o_consume2,
  output logic             o_emit,
  output logic             o_sel_p1_dup,
  output logic             o_sel_p2_dup
);

  // Disjoint and excess genes survive only when they come from the fitter
  // parent (bias=0 -> parent1, bias=1 -> parent2); matching keys always pair.
  always_comb begin
    o_consume1   = 1'b0;
    o_consume2   = 1'b0;
    o_emit       = 1'b0;
    o_sel_p1_dup = 1'b0;
    o_sel_p2_dup = 1'b0;
    if (!(i_p1_ex && i_p2_ex)) begin
      if (i_p1_ex) begin
        if (i_p2_valid) begin
          o_consume2   = 1'b1;
          o_emit       = i_bias;
          o_sel_p2_dup = 1'b1;
        end
      end else if (i_p2_ex) begin
        if (i_p1_valid) begin
          o_consume1   = 1'b1;
          o_emit       = ~i_bias;
          o_sel_p1_dup = 1'b1;
        end
      end else if (i_p1_valid && i_p2_valid) begin
        if (i_key1 == i_key2) begin
          o_consume1 = 1'b1;
          o_consume2 = 1'b1;
          o_emit     = 1'b1;
        end else if (i_key1 < i_key2) begin
          o_consume1   = 1'b1;
          o_emit       = ~i_bias;
          o_sel_p1_dup = 1'b1;
        end else begin
          o_consume2   = 1'b1;
          o_emit       = i_bias;
          o_sel_p2_dup = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/crossover_gene_aligner.sv
// Aligns two key-sorted parent gene streams into one setup beat followed by
// key-matched gene pairs, keeping disjoint/excess genes from the fitter parent.
module crossover_gene_aligner
  import crossover_gene_aligner_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [GENE_SZ-1:0] i_cfg_word1,
  input  logic [GENE_SZ-1:0] i_cfg_word2,
  input  logic               i_p1_valid,
  input  logic [GENE_SZ-1:0] i_p1_gene,
  input  logic               i_p1_last,
  output logic               o_p1_ready,
  input  logic               i_p2_valid,
  input  logic [GENE_SZ-1:0] i_p2_gene,
  input  logic               i_p2_last,
  output logic               o_p2_ready,
  output logic               o_setup,
  output logic [GENE_SZ-1:0] o_data_in1,
  output logic [GENE_SZ-1:0] o_data_in2,
  output logic [GENE_SZ-1:0] o_gene1_out,
  output logic [GENE_SZ-1:0] o_gene2_out,
  output logic               o_bubble,
  output logic               o_bias_out,
  output logic               o_busy,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_gene_count
);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_setup;
  logic               r_bubble;
  logic               r_done;
  logic               r_busy;
  logic               r_bias;
  logic               r_p1_ex;
  logic               r_p2_ex;
  logic [GENE_SZ-1:0] r_data_in1;
  logic [GENE_SZ-1:0] r_data_in2;
  logic [GENE_SZ-1:0] r_gene1;
  logic [GENE_SZ-1:0] r_gene2;
  logic [CNT_W-1:0]   r_count;

  logic [KEY_W-1:0]   w_key1;
  logic [KEY_W-1:0]   w_key2;
  logic               w_consume1;
  logic               w_consume2;
  logic               w_emit;
  logic               w_sel_p1_dup;
  logic               w_sel_p2_dup;
  logic               w_merge;
  logic               w_take1;
  logic               w_take2;
  logic               w_emit_now;

  assign w_key1 = i_p1_gene[KEY_HI:KEY_LO];
  assign w_key2 = i_p2_gene[KEY_HI:KEY_LO];

  gene_merge_decide u_decide (
    .i_p1_valid   (i_p1_valid),
    .i_p2_valid   (i_p2_valid),
    .i_p1_ex      (r_p1_ex),
    .i_p2_ex      (r_p2_ex),
    .i_key1       (w_key1),
    .i_key2       (w_key2),
    .i_bias       (r_bias),
    .o_consume1   (w_consume1),
    .o_consume2   (w_consume2),
    .o_emit       (w_emit),
    .o_sel_p1_dup (w_sel_p1_dup),
    .o_sel_p2_dup (w_sel_p2_dup)
  );

  // Handshakes only happen while merging; ready never waits on a register.
  assign w_merge    = (r_state == MERGE);
  assign w_take1    = w_merge & w_consume1;
  assign w_take2    = w_merge & w_consume2;
  assign w_emit_now = w_merge & w_emit;
  assign o_p1_ready = w_take1;
  assign o_p2_ready = w_take2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_next = SETUP;
      SETUP:   w_state_next = MERGE;
      MERGE:   if (r_p1_ex && r_p2_ex) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // setup/done are single-cycle pulses; bubble defaults high unless a pair lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_setup    <= 1'b0;
      r_bubble   <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_bias     <= 1'b0;
      r_p1_ex    <= 1'b0;
      r_p2_ex    <= 1'b0;
      r_data_in1 <= '0;
      r_data_in2 <= '0;
      r_gene1    <= '0;
      r_gene2    <= '0;
      r_count    <= '0;
    end else begin
      r_setup  <= 1'b0;
      r_done   <= 1'b0;
      r_bubble <= 1'b1;
      r_busy   <= (w_state_next != IDLE);
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_setup    <= 1'b1;
            r_data_in1 <= i_cfg_word1;
            r_data_in2 <= i_cfg_word2;
            r_bias     <= (i_cfg_word1[P2_FIT_HI:P2_FIT_LO] >
                           i_cfg_word1[P1_FIT_HI:P1_FIT_LO]);
            r_count    <= '0;
            r_p1_ex    <= 1'b0;
            r_p2_ex    <= 1'b0;
          end
        end
        MERGE: begin
          if (r_p1_ex && r_p2_ex) r_done <= 1'b1;
          if (w_take1 && i_p1_last) r_p1_ex <= 1'b1;
          if (w_take2 && i_p2_last) r_p2_ex <= 1'b1;
          if (w_emit_now) begin
            r_bubble <= 1'b0;
            r_gene1  <= w_sel_p2_dup ? i_p2_gene : i_p1_gene;
            r_gene2  <= w_sel_p1_dup ? i_p1_gene : i_p2_gene;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_setup      = r_setup;
  assign o_bubble     = r_bubble;
  assign o_done       = r_done;
  assign o_busy       = r_busy;
  assign o_bias_out   = r_bias;
  assign o_data_in1   = r_data_in1;
  assign o_data_in2   = r_data_in2;
  assign o_gene1_out  = r_gene1;
  assign o_gene2_out  = r_gene2;
  assign o_gene_count = r_count;

endmodule

// File: tb/tb_crossover_gene_aligner.sv
// Randomized bench for crossover_gene_aligner; expected pairs come from a
// key-set model of the NEAT inheritance rule.
module tb_crossover_gene_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [63:0] i_cfg_word1;
  logic [63:0] i_cfg_word2;
  logic        i_p1_valid;
  logic [63:0] i_p1_gene;
  logic        i_p1_last;
  logic        o_p1_ready;
  logic        i_p2_valid;
  logic [63:0] i_p2_gene;
  logic        i_p2_last;
  logic        o_p2_ready;
  logic        o_setup;
  logic [63:0] o_data_in1;
  logic [63:0] o_data_in2;
  logic [63:0] o_gene1_out;
  logic [63:0] o_gene2_out;
  logic        o_bubble;
  logic        o_bias_out;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_gene_count;

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] p1Keys[$];
  logic [15:0] p2Keys[$];
  logic [63:0] p1Genes[$];
  logic [63:0] p2Genes[$];
  logic [63:0] expG1[$];
  logic [63:0] expG2[$];

  crossover_gene_aligner dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_cfg_word1  (i_cfg_word1),
    .i_cfg_word2  (i_cfg_word2),
    .i_p1_valid   (i_p1_valid),
    .i_p1_gene    (i_p1_gene),
    .i_p1_last    (i_p1_last),
    .o_p1_ready   (o_p1_ready),
    .i_p2_valid   (i_p2_valid),
    .i_p2_gene    (i_p2_gene),
    .i_p2_last    (i_p2_last),
    .o_p2_ready   (o_p2_ready),
    .o_setup      (o_setup),
    .o_data_in1   (o_data_in1),
    .o_data_in2   (o_data_in2),
    .o_gene1_out  (o_gene1_out),
    .o_gene2_out  (o_gene2_out),
    .o_bubble     (o_bubble),
    .o_bias_out   (o_bias_out),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_gene_count (o_gene_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearStreams();
    p1Keys.delete(); p2Keys.delete(); p1Genes.delete(); p2Genes.delete();
  endtask

  task automatic addGene(input int side, input logic [15:0] key);
    logic [63:0] g;
    g = {8'($urandom), key, 8'($urandom), 32'($urandom)};
    if (side == 1) begin p1Keys.push_back(key); p1Genes.push_back(g); end
    else begin p2Keys.push_back(key); p2Genes.push_back(g); end
  endtask

  task automatic randomStreams(input int n);
    logic [15:0] key;
    int c;
    clearStreams();
    c = $urandom_range(0, 2);
    key = (c == 0) ? 16'h0000 : (c == 1) ? 16'h7FF8 : 16'h8000;
    key = key + 16'($urandom_range(0, 6));
    for (int i = 0; i < n; i++) begin
      key = key + 16'($urandom_range(1, 4));
      c = $urandom_range(0, 2);
      if (c != 2) addGene(1, key);
      if (c != 1) addGene(2, key);
    end
    if (p1Keys.size() == 0) addGene(1, key + 16'd1);
    if (p2Keys.size() == 0) addGene(2, key + 16'd2);
  endtask

  // Walk the union of keys in ascending order: shared keys pair up, keys
  // held by only one parent survive only if that parent is the fitter one.
  task automatic buildExpected(input logic bias);
    logic [63:0] m1[int];
    logic [63:0] m2[int];
    bit          allKeys[int];
    expG1.delete(); expG2.delete();
    foreach (p1Keys[i]) begin m1[int'(p1Keys[i])] = p1Genes[i]; allKeys[int'(p1Keys[i])] = 1'b1; end
    foreach (p2Keys[i]) begin m2[int'(p2Keys[i])] = p2Genes[i]; allKeys[int'(p2Keys[i])] = 1'b1; end
    foreach (allKeys[k]) begin
      if (m1.exists(k) && m2.exists(k)) begin expG1.push_back(m1[k]); expG2.push_back(m2[k]); end
      else if (m1.exists(k) && !bias)   begin expG1.push_back(m1[k]); expG2.push_back(m1[k]); end
      else if (m2.exists(k) && bias)    begin expG1.push_back(m2[k]); expG2.push_back(m2[k]); end
    end
  endtask

  task automatic applyStimulus(input logic [63:0] cfg1, input logic [63:0] cfg2);
    i_start     = 1'b1;
    i_cfg_word1 = cfg1;
    i_cfg_word2 = cfg2;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // mode: 0 always valid, 1 random valid gaps, 2 parent2 stalls for 3 cycles
  task automatic runGenome(input logic [7:0] fit1, input logic [7:0] fit2,
                           input int mode, input bit busyStart);
    logic        bias;
    logic [63:0] cfg1, cfg2;
    int          idx1, idx2, obs, cyc;
    bit          doneSeen, h1, h2, stallNow;
    bias = (fit2 > fit1);
    cfg1 = {fit1, fit2, 16'($urandom), 32'($urandom)};
    cfg2 = {32'($urandom), 32'($urandom)};
    buildExpected(bias);
    applyStimulus(cfg1, cfg2);
    checkOutput("setup beat", 64'(o_setup), 64'd1);
    checkOutput("setup bubble", 64'(o_bubble), 64'd1);
    checkOutput("data_in1", o_data_in1, cfg1);
    checkOutput("data_in2", o_data_in2, cfg2);
    checkOutput("bias at setup", 64'(o_bias_out), 64'(bias));
    checkOutput("count cleared", 64'(o_gene_count), 64'd0);
    idx1 = 0; idx2 = 0; obs = 0; cyc = 0; doneSeen = 1'b0;
    while (!doneSeen && cyc < 2000) begin
      stallNow = (mode == 2) && (cyc >= 2) && (cyc <= 4) && (idx2 < p2Genes.size());
      if (idx1 < p1Genes.size()) begin
        i_p1_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_p1_gene  = p1Genes[idx1];
        i_p1_last  = (idx1 == p1Genes.size() - 1);
      end else begin
        i_p1_valid = 1'b1; i_p1_gene = {$urandom, $urandom}; i_p1_last = 1'b0;
      end
      if (idx2 < p2Genes.size()) begin
        i_p2_valid = stallNow ? 1'b0 : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_p2_gene  = p2Genes[idx2];
        i_p2_last  = (idx2 == p2Genes.size() - 1);
      end else begin
        i_p2_valid = 1'b1; i_p2_gene = {$urandom, $urandom}; i_p2_last = 1'b0;
      end
      if (busyStart && cyc == 2) begin
        i_start = 1'b1; i_cfg_word1 = ~cfg1; i_cfg_word2 = ~cfg2;
      end else begin
        i_start = 1'b0; i_cfg_word1 = cfg1; i_cfg_word2 = cfg2;
      end
      @(negedge clk);
      h1 = i_p1_valid && o_p1_ready;
      h2 = i_p2_valid && o_p2_ready;
      if (cyc == 0) begin
        checkOutput("p1_ready in setup", 64'(o_p1_ready), 64'd0);
        checkOutput("p2_ready in setup", 64'(o_p2_ready), 64'd0);
      end
      if (idx1 >= p1Genes.size()) checkOutput("p1_ready after last", 64'(o_p1_ready), 64'd0);
      if (idx2 >= p2Genes.size()) checkOutput("p2_ready after last", 64'(o_p2_ready), 64'd0);
      if (stallNow) checkOutput("p1_ready during stall", 64'(o_p1_ready), 64'd0);
      @(posedge clk); #1;
      if (h1) idx1++;
      if (h2) idx2++;
      if (stallNow) checkOutput("stall bubble", 64'(o_bubble), 64'd1);
      if (!o_bubble) begin
        if (obs < expG1.size()) begin
          checkOutput($sformatf("pair%0d gene1", obs), o_gene1_out, expG1[obs]);
          checkOutput($sformatf("pair%0d gene2", obs), o_gene2_out, expG2[obs]);
        end else begin
          checkOutput("extra pair", 64'd1, 64'd0);
        end
        obs++;
      end
      if (o_done) doneSeen = 1'b1;
      cyc++;
    end
    i_start = 1'b0; i_cfg_word1 = cfg1; i_cfg_word2 = cfg2;
    i_p1_valid = 1'b0; i_p2_valid = 1'b0;
    checkOutput("done within budget", 64'(doneSeen), 64'd1);
    checkOutput("pairs emitted", 64'(obs), 64'(expG1.size()));
    checkOutput("gene_count at done", 64'(o_gene_count), 64'(expG1.size()));
    checkOutput("p1 fully consumed", 64'(idx1), 64'(p1Genes.size()));
    checkOutput("p2 fully consumed", 64'(idx2), 64'(p2Genes.size()));
    checkOutput("bias held", 64'(o_bias_out), 64'(bias));
    checkOutput("data_in1 held", o_data_in1, cfg1);
    checkOutput("data_in2 held", o_data_in2, cfg2);
    if (doneSeen) begin
      checkOutput("busy in done", 64'(o_busy), 64'd1);
      @(posedge clk); #1;
      checkOutput("busy after done", 64'(o_busy), 64'd0);
      checkOutput("done one cycle", 64'(o_done), 64'd0);
      checkOutput("gene_count holds", 64'(o_gene_count), 64'(expG1.size()));
      checkOutput("idle bubble", 64'(o_bubble), 64'd1);
    end else begin
      rst = 1'b1; #1; rst = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0; i_cfg_word1 = '0; i_cfg_word2 = '0;
    i_p1_valid = 1'b0; i_p1_gene = '0; i_p1_last = 1'b0;
    i_p2_valid = 1'b0; i_p2_gene = '0; i_p2_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset bubble", 64'(o_bubble), 64'd1);
    checkOutput("reset setup", 64'(o_setup), 64'd0);
    checkOutput("reset busy", 64'(o_busy), 64'd0);
    checkOutput("reset done", 64'(o_done), 64'd0);
    checkOutput("reset bias", 64'(o_bias_out), 64'd0);
    checkOutput("reset count", 64'(o_gene_count), 64'd0);
    checkOutput("reset gene1", o_gene1_out, 64'd0);
    checkOutput("reset gene2", o_gene2_out, 64'd0);
    checkOutput("reset data_in1", o_data_in1, 64'd0);
    checkOutput("reset data_in2", o_data_in2, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] matching streams, parent1 fitter");
    clearStreams();
    addGene(1, 16'd1); addGene(1, 16'd2); addGene(1, 16'd4);
    addGene(2, 16'd1); addGene(2, 16'd3); addGene(2, 16'd4);
    runGenome(8'h40, 8'h20, 0, 1'b0);

    $display("[TB] matching streams, parent2 fitter");
    runGenome(8'h40, 8'h50, 0, 1'b0);

    $display("[TB] excess genes from parent2");
    clearStreams();
    addGene(1, 16'd1);
    addGene(2, 16'd1); addGene(2, 16'd5); addGene(2, 16'd6);
    runGenome(8'h10, 8'h30, 0, 1'b0);

    $display("[TB] parent2 stall");
    randomStreams(10);
    runGenome(8'h22, 8'h11, 2, 1'b0);

    $display("[TB] start while busy");
    randomStreams(8);
    runGenome(8'h05, 8'h60, 0, 1'b1);

    $display("[TB] equal fitness");
    randomStreams(8);
    runGenome(8'h33, 8'h33, 1, 1'b0);

    $display("[TB] reset mid-merge");
    randomStreams(10);
    applyStimulus({16'h1020, 48'h0}, 64'd7);
    i_p1_valid = 1'b1; i_p1_gene = p1Genes[0]; i_p1_last = (p1Genes.size() == 1);
    i_p2_valid = 1'b1; i_p2_gene = p2Genes[0]; i_p2_last = (p2Genes.size() == 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort bubble", 64'(o_bubble), 64'd1);
    checkOutput("abort setup", 64'(o_setup), 64'd0);
    checkOutput("abort busy", 64'(o_busy), 64'd0);
    checkOutput("abort count", 64'(o_gene_count), 64'd0);
    checkOutput("abort gene1", o_gene1_out, 64'd0);
    checkOutput("abort p1_ready", 64'(o_p1_ready), 64'd0);
    i_p1_valid = 1'b0; i_p2_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    runGenome(8'h70, 8'h71, 1, 1'b0);

    $display("[TB] random genomes");
    for (int g = 0; g < 20; g++) begin
      randomStreams($urandom_range(1, 16));
      runGenome(8'($urandom), 8'($urandom), $urandom_range(0, 1), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
